// File: rtl/memoria_arbitro.sv
// Ship-position memory arbiter: the placement writer has priority, and the collision and VGA
// readers share the port round-robin. The memory has a 1-cycle synchronous read latency.
module memoria_arbitro #(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 5,
    parameter int NUM_SHIPS = 11
) (
    input  logic              clk,
    input  logic              resetGeral,
    input  logic              wr_req,
    input  logic              wr_jogador,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              col_req,
    input  logic              col_jogador,
    input  logic [ADDR_W-1:0] col_addr,
    output logic              col_gnt,
    output logic              col_valid,
    input  logic              vga_req,
    input  logic              vga_jogador,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              addr_err,
    output logic              mem_we,
    output logic              mem_jogador,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE_WR, ISSUE_RD, WAIT_RD} state_t;

    localparam logic              SRC_COL = 1'b0;
    localparam logic              SRC_VGA = 1'b1;
    localparam logic [ADDR_W-1:0] LIM     = ADDR_W'(NUM_SHIPS);

    state_t            r_state;
    logic              r_src;
    logic              r_bad;
    logic              r_rr_last;
    logic              w_wr_ok;
    logic              w_pick_vga;
    logic              w_rd_jog;
    logic              w_rd_ok;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_ok    = wr_addr < LIM;
    // On a tie, the reader that was not served last wins.
    assign w_pick_vga = vga_req && (!col_req || r_rr_last == SRC_COL);
    assign w_rd_addr  = w_pick_vga ? vga_addr : col_addr;
    assign w_rd_jog   = w_pick_vga ? vga_jogador : col_jogador;
    assign w_rd_ok    = w_rd_addr < LIM;

    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            r_state     <= IDLE;
            r_src       <= SRC_COL;
            r_bad       <= 1'b0;
            r_rr_last   <= SRC_VGA;
            wr_gnt      <= 1'b0;
            col_gnt     <= 1'b0;
            vga_gnt     <= 1'b0;
            col_valid   <= 1'b0;
            vga_valid   <= 1'b0;
            rd_data     <= '0;
            addr_err    <= 1'b0;
            mem_we      <= 1'b0;
            mem_jogador <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            wr_gnt    <= 1'b0;
            col_gnt   <= 1'b0;
            vga_gnt   <= 1'b0;
            col_valid <= 1'b0;
            vga_valid <= 1'b0;
            addr_err  <= 1'b0;
            mem_we    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (wr_req) begin
                        wr_gnt      <= 1'b1;
                        mem_we      <= w_wr_ok;
                        addr_err    <= !w_wr_ok;
                        mem_addr    <= wr_addr;
                        mem_jogador <= wr_jogador;
                        mem_wdata   <= wr_data;
                        r_state     <= ISSUE_WR;
                    end else if (col_req || vga_req) begin
                        col_gnt     <= !w_pick_vga;
                        vga_gnt     <= w_pick_vga;
                        addr_err    <= !w_rd_ok;
                        mem_addr    <= w_rd_addr;
                        mem_jogador <= w_rd_jog;
                        r_bad       <= !w_rd_ok;
                        r_src       <= w_pick_vga ? SRC_VGA : SRC_COL;
                        r_rr_last   <= w_pick_vga ? SRC_VGA : SRC_COL;
                        r_state     <= ISSUE_RD;
                    end
                end
                ISSUE_WR: r_state <= IDLE;
                ISSUE_RD: r_state <= WAIT_RD;
                WAIT_RD: begin
                    // An illegal address still completes, but it returns zero instead of whatever the memory drives.
                    rd_data   <= r_bad ? '0 : mem_rdata;
                    col_valid <= (r_src == SRC_COL);
                    vga_valid <= (r_src == SRC_VGA);
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memoria_arbitro.sv
// Bench for memoria_arbitro. A transaction-level model predicts the grant order and the cycle timing of each batch of requests.
module tb_memoria_arbitro;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NS = 11;

    logic          clk = 1'b0;
    logic          resetGeral;
    logic          wr_req, wr_jogador, wr_gnt;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          col_req, col_jogador, col_gnt, col_valid;
    logic [AW-1:0] col_addr;
    logic          vga_req, vga_jogador, vga_gnt, vga_valid;
    logic [AW-1:0] vga_addr;
    logic [DW-1:0] rd_data;
    logic          addr_err, mem_we, mem_jogador;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    memoria_arbitro #(.DATA_W(DW), .ADDR_W(AW), .NUM_SHIPS(NS)) dut (
        .clk(clk), .resetGeral(resetGeral),
        .wr_req(wr_req), .wr_jogador(wr_jogador), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .col_req(col_req), .col_jogador(col_jogador), .col_addr(col_addr), .col_gnt(col_gnt), .col_valid(col_valid),
        .vga_req(vga_req), .vga_jogador(vga_jogador), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_valid(vga_valid),
        .rd_data(rd_data), .addr_err(addr_err), .mem_we(mem_we), .mem_jogador(mem_jogador),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory: both banks live in one array indexed {bank, addr}. A location that has never been written reads as a nonzero pattern.
    function automatic logic [63:0] init_pat(input logic [5:0] k);
        return {16'hC0DE, 10'd0, k, 32'h5A5A_0000 + 32'(k)};
    endfunction
    logic [63:0] mem [64];
    logic [63:0] wflag = '0;
    always @(posedge clk) begin
        if (mem_we) begin
            mem[{mem_jogador, mem_addr}]   <= mem_wdata;
            wflag[{mem_jogador, mem_addr}] <= 1'b1;
        end
        mem_rdata <= wflag[{mem_jogador, mem_addr}] ? mem[{mem_jogador, mem_addr}]
                                                    : init_pat({mem_jogador, mem_addr});
    end

    typedef struct {
        logic wg, cg, vg, cv, vv, err, we;
        logic [AW-1:0] addr;
        logic          jog;
        logic [DW-1:0] wdata, rd;
    } ev_t;

    ev_t           exp_ev [128];
    logic [DW-1:0] ref_mem [2][NS];
    logic [AW-1:0] wa [16], ca [16], va [16];
    logic          wj [16], cj [16], vj [16];
    logic [DW-1:0] wd [16];
    int            nw, nc, nv;
    int            n_checks = 0;
    int            n_err = 0;
    logic          last_vga;
    logic [DW-1:0] rd_cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Predict the batch from the arbitration rules, then drive the requesters and compare every cycle.
    task automatic run_batch(input string tag);
        int   t, tend, wi, ci, vi;
        logic pv, rearm, bad, jj;
        logic [AW-1:0] aa;
        logic [DW-1:0] dd;
        ev_t  e;
        for (int i = 0; i < 128; i++) exp_ev[i] = '{default: '0};
        t = 1; wi = 0; ci = 0; vi = 0;
        while (wi < nw || ci < nc || vi < nv) begin
            if (wi < nw) begin
                bad = int'(wa[wi]) >= NS;
                exp_ev[t].wg = 1'b1; exp_ev[t].err = bad; exp_ev[t].we = !bad;
                exp_ev[t].addr = wa[wi]; exp_ev[t].jog = wj[wi]; exp_ev[t].wdata = wd[wi];
                if (!bad) ref_mem[wj[wi]][wa[wi]] = wd[wi];
                wi++; t += 2;
            end else begin
                pv = (vi < nv) && (ci >= nc || !last_vga);
                aa = pv ? va[vi] : ca[ci];
                jj = pv ? vj[vi] : cj[ci];
                bad = int'(aa) >= NS;
                dd = bad ? '0 : ref_mem[jj][aa];
                exp_ev[t].vg = pv; exp_ev[t].cg = !pv; exp_ev[t].err = bad;
                exp_ev[t].addr = aa; exp_ev[t].jog = jj;
                exp_ev[t+2].vv = pv; exp_ev[t+2].cv = !pv; exp_ev[t+2].rd = dd;
                if (pv) vi++; else ci++;
                last_vga = pv; t += 3;
            end
        end
        tend = t + 1;
        wi = 0; ci = 0; vi = 0; rearm = 1'b0;
        wr_req = nw > 0;  wr_addr = wa[0];  wr_jogador = wj[0];  wr_data = wd[0];
        col_req = nc > 0; col_addr = ca[0]; col_jogador = cj[0];
        vga_req = nv > 0; vga_addr = va[0]; vga_jogador = vj[0];
        for (int c = 1; c <= tend; c++) begin
            @(negedge clk);
            e = exp_ev[c];
            if (e.cv || e.vv) rd_cur = e.rd;
            chk($sformatf("%s c%0d flags", tag, c),
                64'({wr_gnt, col_gnt, vga_gnt, col_valid, vga_valid, addr_err, mem_we}),
                64'({e.wg, e.cg, e.vg, e.cv, e.vv, e.err, e.we}));
            chk($sformatf("%s c%0d rd_data", tag, c), rd_data, rd_cur);
            if (e.wg || e.cg || e.vg)
                chk($sformatf("%s c%0d mem_addr/jog", tag, c), 64'({mem_jogador, mem_addr}), 64'({e.jog, e.addr}));
            if (e.wg) chk($sformatf("%s c%0d mem_wdata", tag, c), mem_wdata, e.wdata);
            // The collision requester drops its request for one cycle after each grant before asking again.
            if (rearm) begin col_req = ci < nc; rearm = 1'b0; end
            if (wr_gnt) begin
                wi++; wr_req = wi < nw;
                if (wi < nw) begin wr_addr = wa[wi]; wr_jogador = wj[wi]; wr_data = wd[wi]; end
            end
            if (col_gnt) begin
                ci++; col_req = 1'b0; rearm = 1'b1;
                if (ci < nc) begin col_addr = ca[ci]; col_jogador = cj[ci]; end
            end
            if (vga_gnt) begin
                vi++; vga_req = vi < nv;
                if (vi < nv) begin vga_addr = va[vi]; vga_jogador = vj[vi]; end
            end
        end
        wr_req = 1'b0; col_req = 1'b0; vga_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctrl"}, 64'({wr_gnt, col_gnt, vga_gnt, col_valid, vga_valid, addr_err, mem_we, mem_jogador, mem_addr}), 64'd0);
        chk({tag, " rd_data"}, rd_data, 64'd0);
        chk({tag, " mem_wdata"}, mem_wdata, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < 2; j++)
            for (int a = 0; a < NS; a++) ref_mem[j][a] = init_pat(6'(j * 32 + a));
        resetGeral = 1'b1;
        wr_req = 0; wr_jogador = 0; wr_addr = '0; wr_data = '0;
        col_req = 0; col_jogador = 0; col_addr = '0;
        vga_req = 0; vga_jogador = 0; vga_addr = '0;
        last_vga = 1'b1; rd_cur = '0;
        @(negedge clk); @(negedge clk);
        chk_all_zero("reset");
        resetGeral = 1'b0;
        @(negedge clk);

        // Write 0xA5 to bank 1, addr 3, then read it back through the VGA port.
        nw = 1; nc = 0; nv = 0; wa[0] = 5'd3; wj[0] = 1'b1; wd[0] = 64'hA5;
        run_batch("wr_a5");
        nw = 0; nv = 1; va[0] = 5'd3; vj[0] = 1'b1;
        run_batch("vga_a5");

        // All three requesters at once: the write goes first, then col, vga, col.
        nw = 1; nc = 2; nv = 1;
        wa[0] = 5'd5; wj[0] = 1'b0; wd[0] = 64'hDEAD_BEEF_0000_0005;
        ca[0] = 5'd5; cj[0] = 1'b0; ca[1] = 5'd1; cj[1] = 1'b1;
        va[0] = 5'd3; vj[0] = 1'b1;
        run_batch("triple");

        // Last legal address, then the first illegal one.
        nw = 2; nc = 0; nv = 0;
        wa[0] = 5'd10; wj[0] = 1'b0; wd[0] = 64'h1;
        wa[1] = 5'd11; wj[1] = 1'b0; wd[1] = 64'hFFFF;
        run_batch("wr_edge");
        nw = 0; nc = 1; ca[0] = 5'd15; cj[0] = 1'b1;
        run_batch("col_bad");
        nc = 1; ca[0] = 5'd10; cj[0] = 1'b0;
        run_batch("col_10");

        // Reset arrives while a read sits in WAIT_RD.
        col_req = 1'b1; col_addr = 5'd2; col_jogador = 1'b0;
        @(negedge clk);
        chk("rst_rd gnt", 64'(col_gnt), 64'd1);
        col_req = 1'b0;
        @(negedge clk);
        resetGeral = 1'b1;
        #1 chk_all_zero("rst_rd async");
        @(negedge clk);
        chk("rst_rd no valid", 64'({col_valid, vga_valid}), 64'd0);
        resetGeral = 1'b0; last_vga = 1'b1; rd_cur = '0;
        @(negedge clk);
        nw = 0; nc = 1; nv = 0; ca[0] = 5'd2; cj[0] = 1'b0;
        run_batch("after_rst");

        // Reset arrives during a write grant: mem_we clears at once and nothing is written.
        wr_req = 1'b1; wr_addr = 5'd9; wr_jogador = 1'b0; wr_data = 64'h1234;
        @(negedge clk);
        chk("rst_wr we", 64'(mem_we), 64'd1);
        wr_req = 1'b0; resetGeral = 1'b1;
        #1 chk("rst_wr we cleared", 64'({mem_we, wr_gnt}), 64'd0);
        @(negedge clk);
        resetGeral = 1'b0; last_vga = 1'b1; rd_cur = '0;
        @(negedge clk);
        nw = 0; nc = 0; nv = 1; va[0] = 5'd9; vj[0] = 1'b0;
        run_batch("rst_wr_read");

        // VGA sweeps every legal address while the collision requester keeps cutting in.
        nw = 0; nc = 5; nv = NS;
        for (int i = 0; i < NS; i++) begin va[i] = 5'(i); vj[i] = 1'($urandom_range(0, 1)); end
        for (int i = 0; i < 5; i++) begin ca[i] = 5'($urandom_range(0, 12)); cj[i] = 1'($urandom_range(0, 1)); end
        run_batch("sweep");

        for (int b = 0; b < 15; b++) begin
            nw = $urandom_range(0, 2); nc = $urandom_range(0, 2); nv = $urandom_range(0, 2);
            if (nw + nc + nv == 0) nv = 1;
            for (int i = 0; i < 2; i++) begin
                wa[i] = 5'($urandom_range(0, 13)); wj[i] = 1'($urandom_range(0, 1)); wd[i] = {$urandom, $urandom};
                ca[i] = 5'($urandom_range(0, 13)); cj[i] = 1'($urandom_range(0, 1));
                va[i] = 5'($urandom_range(0, 13)); vj[i] = 1'($urandom_range(0, 1));
            end
            run_batch($sformatf("rand%0d", b));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
